mem_access_unit: RTL and testbench

//  Initiator side of the data-memory interface: accepts one load/store per handshake from the MEM stage,

---
 rtl/mau_pkg.sv | 62 ++++++
 rtl/mau_load_align.sv | 32 +++
 rtl/mem_access_unit.sv | 185 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit.
//   - Transfer size codes as carried on the size input.
//   - FSM state encoding.
//   - Width of the bus-wait timer.
//   - Helpers for misalignment detection, byte-enable generation and store-data lane replication.
package mau_pkg;

  localparam int unsigned MAU_TIMER_W = 8;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    RESP = 3'd3,
    ERR  = 3'd4
  } mau_state_e;

  // Size code 2 is illegal, so it is reported as misaligned.
  function automatic logic mau_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    bad = 1'b1;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] mau_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    be = 4'b1111;
    case (size)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the low-aligned store data across every lane it may land in.
  function automatic logic [31:0] mau_wdata(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] wd;
    wd = wdata;
    case (size)
      SZ_BYTE: wd = {4{wdata[7:0]}};
      SZ_HALF: wd = {2{wdata[15:0]}};
      default: wd = wdata;
    endcase
    return wd;
  endfunction

  function automatic logic [31:0] mau_be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/mau_load_align.sv
// Load data alignment and extension.
//   word  in  32  full word returned by the memory
//   off   in  2   byte offset of the load address within the word
//   size  in  2   transfer size code (byte, half, word)
//   isu   in  1   1 = zero-extend, 0 = sign-extend (ignored for words)
//   rdata out 32  selected lane, extended to 32 bits
// Purely combinational.
module mau_load_align
  import mau_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        isu,
  output logic [31:0] rdata
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word[{off, 3'b000} +: 8];
    half_lane = word[{off[1], 4'b0000} +: 16];
    rdata     = word;
    case (size)
      SZ_BYTE: rdata = isu ? {24'h000000, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      SZ_HALF: rdata = isu ? {16'h0000, half_lane} : {{16{half_lane[15]}}, half_lane};
      default: rdata = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory initiator for the MEM stage.
// Accepts one load/store per req_valid/req_ready handshake, drives a word-addressed
// req/gnt/rvalid bus with byte enables, and returns aligned, extended load data with a
// one-cycle resp_valid pulse. Misaligned or illegal-size requests and bus timeouts complete
// with resp_err and no (further) bus activity.
//
// Ports:
//   clk, reset                 clock (rising edge), asynchronous active-low reset
//   req_valid / req_ready      request handshake; ready only while idle
//   is_store, size, isu        operation, size code, zero-extend select for loads
//   addr, wdata, pc            byte address, low-aligned store data, instruction address (trace)
//   resp_valid, resp_err       completion pulse and error flag
//   rdata                      extended load data (0 for stores and errors)
//   mem_req, mem_we, mem_be    bus request, write strobe, byte enables
//   mem_addr, mem_wdata        word-aligned address, lane-replicated store data
//   mem_gnt, mem_rvalid        bus grant and read-data valid
//   mem_rdata                  bus read word
//
// Build option: define MAU_TRACE_EN to print one line per completed store.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              is_store,
  input  logic [1:0]        size,
  input  logic              isu,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [31:0]       pc,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam logic [MAU_TIMER_W-1:0] TimerLast = MAU_TIMER_W'(MAX_WAIT - 1);

  mau_state_e             state_q;
  logic [MAU_TIMER_W-1:0] timer_q;
  logic                   is_store_q;
  logic [1:0]             size_q;
  logic                   isu_q;
  logic [1:0]             off_q;
  logic [31:0]            load_data;

  mau_load_align u_load_align (
    .word  (mem_rdata),
    .off   (off_q),
    .size  (size_q),
    .isu   (isu_q),
    .rdata (load_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      is_store_q <= 1'b0;
      size_q     <= SZ_BYTE;
      isu_q      <= 1'b0;
      off_q      <= 2'b00;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      rdata      <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= 4'b0000;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            is_store_q <= is_store;
            size_q     <= size;
            isu_q      <= isu;
            off_q      <= addr[1:0];
            req_ready  <= 1'b0;
            rdata      <= '0;
            if (mau_misaligned(size, addr[1:0])) begin
              state_q    <= ERR;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              state_q   <= REQ;
              timer_q   <= '0;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_be    <= mau_be(size, addr[1:0]);
              mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
              mem_wdata <= mau_wdata(size, wdata);
            end
          end
        end

        REQ: begin
          // A grant wins over a simultaneous rvalid; that rvalid is dropped.
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (is_store_q) begin
              state_q    <= RESP;
              resp_valid <= 1'b1;
            end else begin
              state_q <= WAIT;
              // The grant cycle is counted as the first cycle of the read wait.
              timer_q <= MAU_TIMER_W'(1);
            end
          end else if (timer_q == TimerLast) begin
            mem_req    <= 1'b0;
            state_q    <= ERR;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
          end else begin
            timer_q <= timer_q + MAU_TIMER_W'(1);
          end
        end

        WAIT: begin
          if (mem_rvalid) begin
            state_q    <= RESP;
            resp_valid <= 1'b1;
            rdata      <= load_data;
          end else if (timer_q == TimerLast) begin
            state_q    <= ERR;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
          end else begin
            timer_q <= timer_q + MAU_TIMER_W'(1);
          end
        end

        RESP, ERR: begin
          state_q   <= IDLE;
          req_ready <= 1'b1;
          rdata     <= '0;
        end

        default: begin
          state_q   <= IDLE;
          req_ready <= 1'b1;
          mem_req   <= 1'b0;
        end
      endcase
    end
  end

`ifdef MAU_TRACE_EN
  logic [31:0] pc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= '0;
    end else if (state_q == IDLE && req_valid) begin
      pc_q <= pc;
    end
  end

  // The old memory word is unknown here, so only the enabled lanes are shown.
  always_ff @(posedge clk) begin
    if (reset && state_q == REQ && mem_gnt && is_store_q) begin
      $display("%d@%h: *%h <= %h", $time, pc_q, mem_addr, mem_wdata & mau_be_mask(mem_be));
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned MAX_WAIT = 255;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              is_store = 1'b0;
  logic [1:0]        size = 2'd0;
  logic              isu = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [31:0]       wdata = '0;
  logic [31:0]       pc = '0;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       rdata;
  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_gnt = 1'b0;
  logic              mem_rvalid = 1'b0;
  logic [31:0]       mem_rdata = '0;

  int checks = 0;
  int errors = 0;
  int req_cycles = 0;

  mem_access_unit #(
    .ADDR_W   (ADDR_W),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .is_store   (is_store),
    .size       (size),
    .isu        (isu),
    .addr       (addr),
    .wdata      (wdata),
    .pc         (pc),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .rdata      (rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_req === 1'b1) req_cycles++;

  // ---------------- reference model (byte-level arithmetic) ----------------
  function automatic int nbytes(input logic [1:0] sz);
    case (sz)
      2'd0: return 1;
      2'd1: return 2;
      2'd3: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit is_bad(input logic [1:0] sz, input logic [31:0] a);
    int nb;
    nb = nbytes(sz);
    if (nb == 0) return 1'b1;
    return (a % nb) != 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [31:0] a);
    logic [3:0] be;
    int lo;
    be = 4'b0000;
    lo = int'(a % 4);
    for (int n = 0; n < 4; n++) if (n >= lo && n < lo + nbytes(sz)) be[n] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] w);
    logic [31:0] v;
    v = '0;
    for (int n = 0; n < 4; n++) v[8*n +: 8] = 8'((w >> (8 * (n % nbytes(sz)))) & 32'hFF);
    return v;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] sz, input bit u, input logic [31:0] a,
                                           input logic [31:0] word);
    logic [31:0] v, mask;
    int bits;
    if (nbytes(sz) == 4) return word;
    bits = 8 * nbytes(sz);
    mask = (32'h1 << bits) - 32'h1;
    v = (word >> (8 * (a % 4))) & mask;
    if (!u && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- generic transaction ----------------
  task automatic do_txn(input bit st, input logic [1:0] sz, input bit u, input logic [31:0] a,
                        input logic [31:0] wd, input int gd, input int rd, input logic [31:0] word,
                        output logic [31:0] got);
    bit bad;
    int rc0;
    logic [31:0] exp_rd;
    bad = is_bad(sz, a);
    rc0 = req_cycles;
    exp_rd = st ? 32'h0 : exp_load(sz, u, a, word);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL ready_before: got %b expected 1", req_ready);
    end
    req_valid = 1'b1; is_store = st; size = sz; isu = u; addr = a; wdata = wd;
    pc = $urandom;
    @(negedge clk);
    req_valid = 1'b0;
    if (bad) begin
      checks++;
      if ({resp_valid, resp_err, mem_req} !== 3'b110) begin
        errors++;
        $display("FAIL err_resp addr=%h size=%0d: got v/e/req=%b expected 110", a, sz,
                 {resp_valid, resp_err, mem_req});
      end
    end else begin
      checks++;
      if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, st, exp_be(sz, a), a & ~32'h3}) begin
        errors++;
        $display("FAIL bus_req addr=%h size=%0d: got req=%b we=%b be=%b addr=%h expected 1 %b %b %h",
                 a, sz, mem_req, mem_we, mem_be, mem_addr, st, exp_be(sz, a), a & ~32'h3);
      end
      if (st) begin
        checks++;
        if (mem_wdata !== exp_wdata(sz, wd)) begin
          errors++;
          $display("FAIL bus_wdata: got %h expected %h", mem_wdata, exp_wdata(sz, wd));
        end
      end
      for (int i = 0; i < gd; i++) begin
        @(negedge clk);
        checks++;
        if ({mem_req, resp_valid} !== 2'b10) begin
          errors++; $display("FAIL req_hold: got req/valid=%b expected 10", {mem_req, resp_valid});
        end
      end
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      checks++;
      if (mem_req !== 1'b0) begin
        errors++; $display("FAIL req_drop: got %b expected 0", mem_req);
      end
      if (!st) begin
        for (int i = 0; i < rd; i++) begin
          checks++;
          if (resp_valid !== 1'b0) begin
            errors++; $display("FAIL early_resp: got %b expected 0", resp_valid);
          end
          @(negedge clk);
        end
        mem_rvalid = 1'b1; mem_rdata = word;
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = $urandom;
      end
      checks++;
      if ({resp_valid, resp_err} !== 2'b10) begin
        errors++; $display("FAIL ok_resp: got v/e=%b expected 10", {resp_valid, resp_err});
      end
    end
    got = rdata;
    checks++;
    if (rdata !== (bad ? 32'h0 : exp_rd)) begin
      errors++;
      $display("FAIL rdata addr=%h size=%0d isu=%b: got %h expected %h", a, sz, u, rdata,
               bad ? 32'h0 : exp_rd);
    end
    @(negedge clk);
    checks++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      errors++; $display("FAIL back_idle: got v/ready=%b expected 01", {resp_valid, req_ready});
    end
    if (bad) begin
      checks++;
      if (req_cycles !== rc0) begin
        errors++; $display("FAIL no_bus_on_err: got %0d req cycles expected 0", req_cycles - rc0);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_err, rdata, mem_req, mem_we, mem_be, mem_addr, mem_wdata}
        !== {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_state: got ready=%b v=%b e=%b rd=%h req=%b we=%b be=%b a=%h wd=%h", req_ready,
               resp_valid, resp_err, rdata, mem_req, mem_we, mem_be, mem_addr, mem_wdata);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] got;
    do_txn(1'b1, 2'd3, 1'b0, 32'h10, 32'hDEADBEEF, 2, 0, 32'h0, got);
    do_txn(1'b1, 2'd0, 1'b0, 32'h13, 32'h000000A5, 0, 0, 32'h0, got);
    do_txn(1'b0, 2'd0, 1'b0, 32'h21, 32'h0, 1, 2, 32'h123480FF, got);
    checks++;
    if (got !== 32'hFFFFFF80) begin
      errors++; $display("FAIL lb_const: got %h expected FFFFFF80", got);
    end
    do_txn(1'b0, 2'd0, 1'b1, 32'h21, 32'h0, 0, 0, 32'h123480FF, got);
    checks++;
    if (got !== 32'h00000080) begin
      errors++; $display("FAIL lbu_const: got %h expected 00000080", got);
    end
    do_txn(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 0, 1, 32'h80010000, got);
    checks++;
    if (got !== 32'hFFFF8001) begin
      errors++; $display("FAIL lh_const: got %h expected FFFF8001", got);
    end
    do_txn(1'b0, 2'd3, 1'b0, 32'h6, 32'h0, 0, 0, 32'h0, got);
    do_txn(1'b1, 2'd2, 1'b0, 32'h8, 32'h1, 0, 0, 32'h0, got);
  endtask

  task automatic test_timeout_req();
    int n;
    bit seen;
    req_valid = 1'b1; is_store = 1'b1; size = 2'd3; addr = 32'h200; wdata = 32'h1;
    @(negedge clk);
    req_valid = 1'b0;
    n = 1; seen = 1'b0;
    while (n < 400) begin
      if (resp_valid === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
      n++;
    end
    checks++;
    if (!seen || n != MAX_WAIT + 1 || resp_err !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL req_timeout: got seen=%b cycles=%0d err=%b req=%b expected 1 %0d 1 0", seen, n,
               resp_err, mem_req, MAX_WAIT + 1);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout_wait();
    int n;
    bit seen;
    req_valid = 1'b1; is_store = 1'b0; size = 2'd3; isu = 1'b0; addr = 32'h100;
    @(negedge clk);
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    n = 1; seen = 1'b0;
    while (n < 400) begin
      if (resp_valid === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
      n++;
    end
    checks++;
    if (!seen || n != MAX_WAIT || resp_err !== 1'b1 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL wait_timeout: got seen=%b cycles=%0d err=%b rdata=%h expected 1 %0d 1 0", seen,
               n, resp_err, rdata, MAX_WAIT);
    end
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    mem_rvalid = 1'b0;
    checks++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      errors++; $display("FAIL late_rvalid: got v/ready=%b expected 01", {resp_valid, req_ready});
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got;
    // Reset while the request is outstanding.
    req_valid = 1'b1; is_store = 1'b0; size = 2'd3; addr = 32'h40;
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if ({mem_req, resp_valid, req_ready} !== 3'b001) begin
      errors++;
      $display("FAIL reset_in_req: got req/v/ready=%b expected 001", {mem_req, resp_valid, req_ready});
    end
    @(negedge clk);
    reset = 1'b1; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    checks++;
    if ({mem_req, resp_valid, req_ready} !== 3'b001) begin
      errors++;
      $display("FAIL late_gnt: got req/v/ready=%b expected 001", {mem_req, resp_valid, req_ready});
    end
    // Reset while waiting for read data.
    req_valid = 1'b1; addr = 32'h44;
    @(negedge clk);
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if ({mem_req, resp_valid, req_ready} !== 3'b001) begin
      errors++;
      $display("FAIL reset_in_wait: got req/v/ready=%b expected 001", {mem_req, resp_valid, req_ready});
    end
    @(negedge clk);
    reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
    @(negedge clk);
    mem_rvalid = 1'b0;
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL late_rvalid_after_reset: got %b expected 0", resp_valid);
    end
    do_txn(1'b0, 2'd1, 1'b1, 32'h46, 32'h0, 1, 1, 32'hBEEF1234, got);
  endtask

  task automatic test_back_to_back();
    int cnt;
    cnt = 0;
    req_valid = 1'b1; is_store = 1'b1; size = 2'd3; addr = 32'h80; wdata = 32'h0BADF00D;
    mem_gnt = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) cnt++;
    end
    req_valid = 1'b0; mem_gnt = 1'b0;
    @(negedge clk);
    checks++;
    if (cnt != 3 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back: got %0d responses ready=%b expected 3 responses ready=1", cnt,
               req_ready);
    end
  endtask

  task automatic test_random();
    logic [31:0] got, a;
    logic [1:0] sz;
    int pick;
    for (int i = 0; i < 60; i++) begin
      pick = $urandom_range(0, 9);
      sz = (pick < 3) ? 2'd0 : (pick < 6) ? 2'd1 : (pick < 9) ? 2'd3 : 2'd2;
      a = $urandom;
      if (sz != 2'd2 && $urandom_range(0, 7) != 0) a = a & ~(32'(nbytes(sz)) - 32'h1);
      do_txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom, got);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_timeout_req();
    test_timeout_wait();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
